// File: rtl/fir_coeff_commit.sv
// fir_coeff_commit: waits for the software coefficient word to settle, then
// commits both packed taps to the FIR datapath together on a frame boundary.
module fir_coeff_commit #(
    parameter int COEF_W        = 16,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic                  user_clk,
    input  logic                  user_rst_n,
    input  logic [2*COEF_W-1:0]   user_data_in,
    input  logic                  sync_in,
    output logic [COEF_W-1:0]     coef_even,
    output logic [COEF_W-1:0]     coef_odd,
    output logic                  coef_load,
    output logic                  pending,
    output logic [CNT_W-1:0]      commit_count
);

    localparam int W  = 2 * COEF_W;
    // Counter only needs to reach STABLE_CYCLES-1; keep at least one bit.
    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ARMED  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [W-1:0]     in_q;
    logic [W-1:0]     cand, cand_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic [W-1:0]     active, active_next;
    logic             load_next;
    logic [CNT_W-1:0] count_next;

    // Input capture register; every decision looks at this delayed copy.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            in_q <= '0;
        end else begin
            in_q <= user_data_in;
        end
    end

    // State and datapath registers.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state        <= IDLE;
            cand         <= '0;
            cnt          <= '0;
            active       <= '0;
            coef_load    <= 1'b0;
            commit_count <= '0;
        end else begin
            state        <= state_next;
            cand         <= cand_next;
            cnt          <= cnt_next;
            active       <= active_next;
            coef_load    <= load_next;
            commit_count <= count_next;
        end
    end

    // Next-state logic: settle a candidate, arm, then commit on sync.
    always_comb begin
        state_next  = state;
        cand_next   = cand;
        cnt_next    = cnt;
        active_next = active;
        load_next   = 1'b0;
        count_next  = commit_count;
        unique case (state)
            IDLE: begin
                if (in_q != active) begin
                    cand_next  = in_q;
                    cnt_next   = '0;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (in_q == active) begin
                    state_next = IDLE;
                end else if (in_q != cand) begin
                    cand_next = in_q;
                    cnt_next  = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = ARMED;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            ARMED: begin
                // Sync has priority: a same-cycle input change is picked
                // up again from IDLE after this commit.
                if (sync_in) begin
                    active_next = cand;
                    load_next   = 1'b1;
                    count_next  = commit_count + CNT_W'(1);
                    state_next  = IDLE;
                end else if (in_q == active) begin
                    state_next = IDLE;
                end else if (in_q != cand) begin
                    cand_next  = in_q;
                    cnt_next   = '0;
                    state_next = SETTLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign coef_even = active[W-1:COEF_W];
    assign coef_odd  = active[COEF_W-1:0];
    assign pending   = (state != IDLE);

endmodule

// File: tb/tb_fir_coeff_commit.sv
// Bench for fir_coeff_commit: directed stimulus, a behavioural model checked
// every cycle, plus literal expectations at the key points of each scenario.
module tb_fir_coeff_commit;

    localparam int COEF_W = 16;
    localparam int S      = 4;
    localparam int CNT_W  = 2;

    logic              user_clk;
    logic              user_rst_n;
    logic [31:0]       user_data_in;
    logic              sync_in;
    logic [15:0]       coef_even;
    logic [15:0]       coef_odd;
    logic              coef_load;
    logic              pending;
    logic [CNT_W-1:0]  commit_count;

    int total = 0;
    int bad   = 0;

    fir_coeff_commit #(.COEF_W(COEF_W), .STABLE_CYCLES(S), .CNT_W(CNT_W)) dut (
        .user_clk     (user_clk),
        .user_rst_n   (user_rst_n),
        .user_data_in (user_data_in),
        .sync_in      (sync_in),
        .coef_even    (coef_even),
        .coef_odd     (coef_odd),
        .coef_load    (coef_load),
        .pending      (pending),
        .commit_count (commit_count)
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a change is "waiting" until it has been seen equal
    // for S consecutive edges, after which any sync edge commits it.
    logic [31:0]      m_inq, m_act, m_cand;
    logic             m_wait, m_load;
    int               m_stable;
    logic [CNT_W-1:0] m_count;

    always @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            m_inq = 0; m_act = 0; m_cand = 0; m_wait = 0; m_load = 0;
            m_stable = 0; m_count = 0;
        end else begin
            m_load = 0;
            if (!m_wait) begin
                if (m_inq != m_act) begin
                    m_wait = 1; m_cand = m_inq; m_stable = 0;
                end
            end else if (m_stable >= S && sync_in) begin
                m_act = m_cand; m_load = 1; m_count = m_count + 1'b1; m_wait = 0;
            end else if (m_inq == m_act) begin
                m_wait = 0;
            end else if (m_inq != m_cand) begin
                m_cand = m_inq; m_stable = 0;
            end else if (m_stable < S) begin
                m_stable++;
            end
            m_inq = user_data_in;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge user_clk) begin
        check("cycle", {28'd0, coef_even, coef_odd, coef_load, pending, commit_count},
              {28'd0, m_act, m_load, m_wait, m_count});
    end

    task automatic tick(input int n);
        repeat (n) @(posedge user_clk);
        #2;
    endtask

    task automatic chk_coef(input string name, input logic [31:0] exp);
        check(name, {32'd0, coef_even, coef_odd}, {32'd0, exp});
    endtask

    initial begin
        // Reset with arbitrary inputs.
        user_rst_n = 1'b0; user_data_in = 32'h00000055; sync_in = 1'b1;
        tick(3);
        check("rst_all", {coef_even, coef_odd, coef_load, pending, commit_count}, 0);
        user_data_in = 32'h0;
        user_rst_n = 1'b1;
        tick(10);
        check("zero_no_load", {coef_load, pending, commit_count}, 0);

        // Basic commit, sync held high.
        user_data_in = 32'h1234ABCD;
        tick(6);
        check("basic_pre_load", coef_load, 0);
        check("basic_pre_pend", pending, 1);
        tick(1);
        chk_coef("basic_coef", 32'h1234ABCD);
        check("basic_load", coef_load, 1);
        check("basic_pend", pending, 0);
        check("basic_cnt", commit_count, 1);
        tick(1);
        check("basic_load_1cyc", coef_load, 0);

        // Glitching write: toggle every 2 cycles, then hold the last value.
        for (int p = 0; p < 10; p++) begin
            user_data_in = (p % 2 == 1) ? 32'h00030004 : 32'h00010002;
            tick(1); check("glitch_load", coef_load, 0);
            tick(1); check("glitch_load", coef_load, 0);
        end
        tick(4);
        check("glitch_early", coef_load, 0);
        tick(1);
        check("glitch_commit", coef_load, 1);
        chk_coef("glitch_coef", 32'h00030004);
        check("glitch_cnt", commit_count, 2);

        // Sync gating: armed but no frame boundary for 100 cycles.
        sync_in = 1'b0; user_data_in = 32'h0BAD0F00;
        tick(6);
        check("gate_armed", pending, 1);
        tick(100);
        check("gate_pend", pending, 1);
        chk_coef("gate_hold", 32'h00030004);
        sync_in = 1'b1;
        tick(1);
        sync_in = 1'b0;
        check("gate_load", coef_load, 1);
        chk_coef("gate_coef", 32'h0BAD0F00);
        check("gate_cnt", commit_count, 3);
        tick(1);

        // Revert: establish 0x11112222 (fourth commit wraps the counter).
        sync_in = 1'b1; user_data_in = 32'h11112222;
        tick(7);
        check("wrap_load", coef_load, 1);
        check("wrap_cnt", commit_count, 0);
        tick(1);
        user_data_in = 32'h33334444;
        tick(3);
        check("revert_settle", pending, 1);
        user_data_in = 32'h11112222;
        tick(2);
        check("revert_idle", pending, 0);
        tick(10);
        check("revert_cnt", commit_count, 0);
        chk_coef("revert_coef", 32'h11112222);
        check("revert_noload", coef_load, 0);

        // Sync wins over a same-cycle input change.
        sync_in = 1'b0; user_data_in = 32'h0A0A0B0B;
        tick(6);
        check("win_armed", pending, 1);
        user_data_in = 32'h0C0C0D0D;
        tick(1);
        sync_in = 1'b1;
        tick(1);
        chk_coef("win_coef", 32'h0A0A0B0B);
        check("win_load", coef_load, 1);
        tick(1);
        check("win_repend", pending, 1);
        tick(5);
        chk_coef("win_second", 32'h0C0C0D0D);
        check("win_cnt", commit_count, 2);

        // Reset while armed clears everything immediately.
        sync_in = 1'b0; user_data_in = 32'h77778888;
        tick(6);
        check("rst_armed", pending, 1);
        #1 user_rst_n = 1'b0;
        #1 check("rst_mid", {coef_even, coef_odd, coef_load, pending, commit_count}, 0);
        tick(2);
        user_rst_n = 1'b1; sync_in = 1'b1;
        tick(6);
        check("rst_no_early", coef_load, 0);
        tick(1);
        check("rst_recommit", coef_load, 1);
        chk_coef("rst_coef", 32'h77778888);
        check("rst_cnt", commit_count, 1);
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_coeff_commit.md
# fir_coeff_commit

Consumer stage for the FIR coefficient software registers on the `user_clk` side of the channelizer. It takes the 32-bit `user_data_out` word of a coefficient register (two packed 16-bit taps, e.g. b6/b7). It waits until software has stopped changing that word, then commits both taps to the FIR datapath together, only on a PFB frame boundary (`sync_in`). This prevents the filter from running with half-written or mid-frame coefficients.

## Interface
- `COEF_W`, 16, width of each tap. Input word is `2*COEF_W` bits.
- `STABLE_CYCLES`, 4, number of consecutive cycles the candidate word must hold before arming. Legal range is 1 or more.
- `CNT_W`, 16, width of the commit counter.

Ports:
- `user_clk`, in, 1, sole clock.
- `user_rst_n`, in, 1, reset. Asynchronous, active-low.
- `user_data_in`, in, 2*COEF_W, register word from the software register. Upper half is the even tap (b6); lower half is the odd tap (b7).
- `sync_in`, in, 1, frame-boundary pulse from the PFB sync chain.
- `coef_even`, out, COEF_W, committed upper tap.
- `coef_odd`, out, COEF_W, committed lower tap.
- `coef_load`, out, 1, one-cycle pulse. It is high in the same cycle the new coefficient values first appear.
- `pending`, out, 1, high while a change is settling or waiting for sync.
- `commit_count`, out, CNT_W, number of commits. Wraps modulo 2^CNT_W.

## Operation
- `in_q` registers `user_data_in` every cycle. All comparisons use `in_q`.
- `active` is the concatenation `{coef_even, coef_odd}`.
- `cand` is the candidate word. `cnt` is the stability counter.

States (`pending = (state != IDLE)`):
- **IDLE**
  - If `in_q != active`: `cand <= in_q`, `cnt <= 0`, go to SETTLE.
- **SETTLE**, rules applied in priority order:
  1. If `in_q == active`: go to IDLE. No commit.
  2. Else if `in_q != cand`: `cand <= in_q`, `cnt <= 0`, stay in SETTLE.
  3. Else if `cnt == STABLE_CYCLES-1`: go to ARMED.
  4. Else `cnt <= cnt+1`.
- **ARMED**, rules applied in priority order:
  1. If `sync_in`: `coef_even/coef_odd <= cand`, `coef_load <= 1`, `commit_count <= commit_count+1`, go to IDLE. This applies even if `in_q` changed in the same cycle: sync wins, and the new value is picked up from IDLE on the next cycle.
  2. Else if `in_q == active`: go to IDLE.
  3. Else if `in_q != cand`: `cand <= in_q`, `cnt <= 0`, go to SETTLE.
- `sync_in` is ignored in IDLE and SETTLE.
- `coef_load` is 0 in every cycle except the one following a commit edge.
- `commit_count` wraps from all-ones to 0 without any other effect.
- Coefficients are passed through as raw bits. Signedness is interpreted downstream.

## Timing
- Reset (`user_rst_n` low) is asynchronous and takes effect immediately, including in mid-operation. All of the following are cleared to 0: `coef_even`, `coef_odd`, `coef_load`, `pending`, `commit_count`, `in_q`, `cand`, `cnt`. State returns to IDLE.
- After reset, a nonzero register word is treated as a change and is committed normally.
- Edge numbering: `user_data_in` changes before edge 1.
  - Edge 1: `in_q` takes the new value.
  - Edge 2: state goes to SETTLE and `pending` rises.
  - Edge 2+STABLE_CYCLES: state goes to ARMED.
  - First edge with `sync_in` high after that: commit.
- Minimum change-to-coefficient latency is STABLE_CYCLES+3 edges, i.e. 7 with the default.
- A commit needs a full STABLE_CYCLES run of identical `in_q` values. Any change restarts the count.
- Throughput is at most one commit per two cycles, since IDLE is always visited between commits.

## Test plan
- **Reset:** assert `user_rst_n` low with any inputs. Required: all outputs are 0 and `pending` is 0. Holding `user_data_in` = 0 produces no `coef_load`.
- **Basic commit:** after reset, drive `user_data_in` = 0x1234ABCD with `sync_in` held high. Required after edge 7: `coef_even` = 0x1234, `coef_odd` = 0xABCD, `coef_load` high for exactly 1 cycle, `commit_count` = 1, `pending` falls in the same cycle.
- **Glitching write:** toggle the input between 0x00010002 and 0x00030004 every 2 cycles for 20 cycles, then hold 0x00030004, with `sync_in` high throughout. Required: no `coef_load` during toggling. Commit of 0x0003/0x0004 occurs exactly 7 edges after the last change.
- **Sync gating:** reach ARMED, then hold `sync_in` low for 100 cycles. Required: `pending` stays 1 and the coefficients are unchanged. A single `sync_in` pulse then commits on that edge.
- **Revert:** from active 0x11112222, write 0x33334444 and then restore 0x11112222 during SETTLE. Required: return to IDLE, no `coef_load`, `commit_count` unchanged.
- **Reset mid-ARMED and counter wrap:** with `CNT_W` = 2, perform 4 commits and check `commit_count` sequence 1, 2, 3, 0. Then assert reset while in ARMED. Required: immediate clear of all outputs, no commit afterwards until a new settle completes.
